// File: rtl/mpu9250_burst_sequencer.sv
// mpu9250_burst_sequencer: command sequencer in front of an i2c_master.
// After start it issues a one-time PWR_MGMT_1 wake-up write, then on every
// sample tick a pointer write to ACCEL_XOUT_H followed by a 14-byte burst
// read. The seven big-endian words are published together with a one-cycle
// sample_valid strobe.
//
// Master handshake: en together with addr/write/wdata/multibyte_n is an
// offer that is held unchanged until the master accepts it (act=1). Every
// next pulse completes one byte. The following clk updates en/write/wdata/
// multibyte_n for the next byte, and those values are then held until the
// next pulse or until act=0. Dropping en after a next pulse ends the
// transaction: the master NACKs a pending read and sends STOP. An err pulse
// is a NACK from the slave. It takes priority over a next pulse in the same
// cycle.
module mpu9250_burst_sequencer #(
  parameter int unsigned SYSTEM_CLOCK = 100_000_000,
  parameter int unsigned SAMPLE_RATE  = 100,
  parameter logic [6:0]  DEV_ADDR     = 7'h68,
  parameter logic [7:0]  PWR_REG      = 8'h6B,
  parameter logic [7:0]  PWR_VAL      = 8'h01,
  parameter logic [7:0]  BURST_REG    = 8'h3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        i2c_en,
  output logic [6:0]  i2c_addr,
  output logic        i2c_write,
  output logic [7:0]  i2c_wdata,
  output logic        i2c_multibyte_n,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_act,
  input  logic        i2c_err,
  input  logic        i2c_next,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        nack_err,
  output logic        overrun,
  output logic [2:0]  state_dbg
);

  localparam int unsigned TICK_PERIOD = SYSTEM_CLOCK / SAMPLE_RATE;
  localparam int unsigned CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_REG = 3'd1,
    INIT_VAL = 3'd2,
    PTR      = 3'd3,
    READ     = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  tick_cnt;
  logic           tick;
  logic           start_q;
  logic [3:0]     k, k_d;
  logic [111:0]   rx_buf, buf_d;
  logic           init_done, init_done_d;
  logic           xfer_init, xfer_init_d;
  logic           xfer_ok, xfer_ok_d;
  logic           en_d, write_d, mb_d;
  logic [7:0]     wdata_d;
  logic           nack_d, overrun_d;
  logic           publish;

  assign i2c_addr  = DEV_ADDR;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign tick      = start && (tick_cnt == CW'(TICK_PERIOD - 1));

  // Sample-period counter; runs only while start is high and wraps on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!start || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic plus next values of the master controls and flags.
  always_comb begin
    state_d     = state;
    en_d        = i2c_en;
    write_d     = i2c_write;
    wdata_d     = i2c_wdata;
    mb_d        = i2c_multibyte_n;
    k_d         = k;
    buf_d       = rx_buf;
    init_done_d = init_done;
    xfer_init_d = xfer_init;
    xfer_ok_d   = xfer_ok;
    nack_d      = nack_err;
    overrun_d   = overrun;
    publish     = 1'b0;

    if (start && !start_q) begin
      nack_d    = 1'b0;
      overrun_d = 1'b0;
    end
    // A tick that finds a transaction in flight is recorded and dropped.
    if (tick && state != IDLE) overrun_d = 1'b1;

    if (state != IDLE && i2c_err) begin
      nack_d    = 1'b1;
      en_d      = 1'b0;
      xfer_ok_d = 1'b0;
      state_d   = DRAIN;
    end else begin
      case (state)
        IDLE: begin
          if (start && !init_done) begin
            state_d     = INIT_REG;
            en_d        = 1'b1;
            write_d     = 1'b1;
            wdata_d     = PWR_REG;
            mb_d        = 1'b0;
            xfer_init_d = 1'b1;
            xfer_ok_d   = 1'b0;
          end else if (start && tick) begin
            state_d     = PTR;
            en_d        = 1'b1;
            write_d     = 1'b1;
            wdata_d     = BURST_REG;
            mb_d        = 1'b0;
            xfer_init_d = 1'b0;
            xfer_ok_d   = 1'b0;
          end
        end
        INIT_REG: begin
          if (i2c_next) begin
            state_d = INIT_VAL;
            wdata_d = PWR_VAL;
          end
        end
        INIT_VAL: begin
          if (i2c_next) begin
            en_d      = 1'b0;
            xfer_ok_d = 1'b1;
            state_d   = DRAIN;
          end
        end
        PTR: begin
          if (i2c_next) begin
            // Direction change forces a repeated start into the read.
            write_d = 1'b0;
            mb_d    = 1'b1;
            k_d     = 4'd0;
            state_d = READ;
          end
        end
        READ: begin
          if (i2c_next) begin
            buf_d = {rx_buf[103:0], i2c_rdata};
            k_d   = k + 4'd1;
            if (k == 4'd13) begin
              en_d      = 1'b0;
              xfer_ok_d = 1'b1;
              state_d   = DRAIN;
            end else begin
              mb_d = 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!i2c_act) begin
            state_d = IDLE;
            if (xfer_ok) begin
              if (xfer_init) init_done_d = 1'b1;
              else           publish     = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Master controls, byte buffer, flags and the published sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_en          <= 1'b0;
      i2c_write       <= 1'b1;
      i2c_wdata       <= 8'h00;
      i2c_multibyte_n <= 1'b1;
      k               <= 4'd0;
      rx_buf          <= '0;
      init_done       <= 1'b0;
      xfer_init       <= 1'b0;
      xfer_ok         <= 1'b0;
      nack_err        <= 1'b0;
      overrun         <= 1'b0;
      start_q         <= 1'b0;
      sample_valid    <= 1'b0;
      accel_x         <= '0;
      accel_y         <= '0;
      accel_z         <= '0;
      temp            <= '0;
      gyro_x          <= '0;
      gyro_y          <= '0;
      gyro_z          <= '0;
    end else begin
      i2c_en          <= en_d;
      i2c_write       <= write_d;
      i2c_wdata       <= wdata_d;
      i2c_multibyte_n <= mb_d;
      k               <= k_d;
      rx_buf          <= buf_d;
      init_done       <= init_done_d;
      xfer_init       <= xfer_init_d;
      xfer_ok         <= xfer_ok_d;
      nack_err        <= nack_d;
      overrun         <= overrun_d;
      start_q         <= start;
      sample_valid    <= publish;
      if (publish) begin
        accel_x <= rx_buf[111:96];
        accel_y <= rx_buf[95:80];
        accel_z <= rx_buf[79:64];
        temp    <= rx_buf[63:48];
        gyro_x  <= rx_buf[47:32];
        gyro_y  <= rx_buf[31:16];
        gyro_z  <= rx_buf[15:0];
      end
    end
  end

endmodule
